// File: rtl/pcs_bip_pkg.sv
// pcs_bip_pkg
// Shared definitions for the per-lane BIP8 engine of the 100GbE PCS.
//   LEN_CODED_BLOCK       : width of one 66-bit coded block
//   BIP3_MSB/LSB          : lane bit positions of the BIP3 field (bit j at 39-j)
//   BIP7_MSB/LSB          : lane bit positions of the BIP7 field (bit j at 7-j)
//   bip8_parity()         : per-block BIP8 parity contribution P
//   bit_rev8()            : maps a BIP value onto its field slice and back
// Lane bit 65 carries D[0], the first transmitted bit, so D[k] = blk[65-k].
package pcs_bip_pkg;

  localparam int LEN_CODED_BLOCK = 66;

  localparam int BIP3_MSB = 39;
  localparam int BIP3_LSB = 32;
  localparam int BIP7_MSB = 7;
  localparam int BIP7_LSB = 0;

  // D[2..65] fold onto P[(k-2) mod 8]; the two sync bits add into P[3]/P[4].
  function automatic logic [7:0] bip8_parity(input logic [LEN_CODED_BLOCK-1:0] blk);
    logic [7:0] p;
    p = '0;
    for (int k = 2; k < LEN_CODED_BLOCK; k++) begin
      p[3'((k - 2) % 8)] = p[3'((k - 2) % 8)] ^ blk[7'(65 - k)];
    end
    p[3] = p[3] ^ blk[65];
    p[4] = p[4] ^ blk[64];
    return p;
  endfunction

  // Field bit j lives at slice bit 7-j, so the slice is the bit-reversed value.
  function automatic logic [7:0] bit_rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bip_lane_acc.sv
// bip_lane_acc
// One PCS lane: BIP8 accumulator, primed flag, RX compare with saturating
// error counter, and TX BIP3/BIP7 field replacement in AM blocks.
//   i_clock, i_reset     : clock, async active-low reset
//   i_enable             : cycle qualifier
//   i_rx_mode            : 0 = insert BIP fields, 1 = check BIP3
//   i_clear_cnt          : synchronous clear of the error counter
//   i_clr_primed         : drop the primed flag (mode change)
//   i_am                 : current block is an alignment marker
//   i_err_inject         : invert bit0 of both inserted fields (TX AM only)
//   i_block / o_block    : coded block in / registered block out
//   o_bip3               : BIP3 value latched at the last AM
//   o_bip_error          : one-cycle pulse on RX mismatch
//   o_err_count          : saturating mismatch counter
module bip_lane_acc
  import pcs_bip_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_rx_mode,
  input  logic                       i_clear_cnt,
  input  logic                       i_clr_primed,
  input  logic                       i_am,
  input  logic                       i_err_inject,
  input  logic [LEN_CODED_BLOCK-1:0] i_block,
  output logic [LEN_CODED_BLOCK-1:0] o_block,
  output logic [7:0]                 o_bip3,
  output logic                       o_bip_error,
  output logic [ERR_CNT_W-1:0]       o_err_count
);

  logic [7:0]                 acc_q, acc_d;
  logic                       primed_q, primed_d;
  logic [LEN_CODED_BLOCK-1:0] block_q, block_d;
  logic [7:0]                 bip3_q, bip3_d;
  logic                       err_q, err_d;
  logic [ERR_CNT_W-1:0]       cnt_q, cnt_d;

  logic [LEN_CODED_BLOCK-1:0] tx_block;
  logic [7:0]                 inj_mask;
  logic                       mismatch;

  always_comb begin
    acc_d    = acc_q;
    primed_d = primed_q;
    block_d  = block_q;
    bip3_d   = bip3_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;

    // Injection flips bit0 of both fields so BIP7 remains the complement of BIP3.
    inj_mask = {7'b0, i_err_inject};
    tx_block = i_block;
    tx_block[BIP3_MSB:BIP3_LSB] = bit_rev8(acc_q ^ inj_mask);
    tx_block[BIP7_MSB:BIP7_LSB] = bit_rev8(~acc_q ^ inj_mask);

    mismatch = primed_q && (bit_rev8(i_block[BIP3_MSB:BIP3_LSB]) != acc_q);

    if (i_enable) begin
      block_d = i_block;
      if (!i_am) begin
        acc_d = acc_q ^ bip8_parity(i_block);
      end else begin
        bip3_d = acc_q;
        if (i_rx_mode) begin
          acc_d    = bip8_parity(i_block);
          primed_d = 1'b1;
          if (mismatch) begin
            err_d = 1'b1;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end else begin
          // The next period starts from the AM exactly as it goes out on the wire.
          block_d = tx_block;
          acc_d   = bip8_parity(tx_block);
        end
      end
    end

    if (i_clr_primed) begin
      primed_d = 1'b0;
    end
    if (i_clear_cnt) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      acc_q    <= '0;
      primed_q <= 1'b0;
      block_q  <= '0;
      bip3_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      primed_q <= primed_d;
      block_q  <= block_d;
      bip3_q   <= bip3_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_block     = block_q;
  assign o_bip3      = bip3_q;
  assign o_bip_error = err_q;
  assign o_err_count = cnt_q;

endmodule

// File: rtl/bip_multilane_calc.sv
// bip_multilane_calc
// Per-lane BIP8 engine for the 100GbE PCS: N_LANES coded blocks per cycle,
// one independent accumulator per lane. TX inserts BIP3/BIP7 into AMs,
// RX checks BIP3 and keeps saturating per-lane error counters.
//   i_clock, i_reset : clock, async active-low reset
//   i_enable         : cycle qualifier (o_valid is its registered copy)
//   i_rx_mode        : 0 = TX insert, 1 = RX check
//   i_clear_cnt      : synchronous clear of all error counters
//   i_data           : lane l at [66*l+65 : 66*l]
//   i_am_insert      : per-lane AM flag
//   i_err_inject     : per-lane BIP corruption, only with BIP_ERR_INJECT_EN
//   o_data, o_valid, o_bip3, o_bip_error, o_err_count : registered results
// Optional feature macro: BIP_ERR_INJECT_EN (adds i_err_inject).
module bip_multilane_calc #(
  parameter int N_LANES         = 20,
  parameter int LEN_CODED_BLOCK = 66,
  parameter int ERR_CNT_W       = 16
) (
  input  logic                               i_clock,
  input  logic                               i_reset,
  input  logic                               i_enable,
  input  logic                               i_rx_mode,
  input  logic                               i_clear_cnt,
  input  logic [N_LANES*LEN_CODED_BLOCK-1:0] i_data,
  input  logic [N_LANES-1:0]                 i_am_insert,
`ifdef BIP_ERR_INJECT_EN
  input  logic [N_LANES-1:0]                 i_err_inject,
`endif
  output logic [N_LANES*LEN_CODED_BLOCK-1:0] o_data,
  output logic                               o_valid,
  output logic [N_LANES*8-1:0]               o_bip3,
  output logic [N_LANES-1:0]                 o_bip_error,
  output logic [N_LANES*ERR_CNT_W-1:0]       o_err_count
);

  import pcs_bip_pkg::*;

  logic                 rx_mode_q, rx_mode_d;
  logic                 valid_q, valid_d;
  logic                 clr_primed;
  logic [N_LANES-1:0]   err_inject_w;

`ifdef BIP_ERR_INJECT_EN
  assign err_inject_w = i_err_inject;
`else
  assign err_inject_w = '0;
`endif

  always_comb begin
    rx_mode_d = i_rx_mode;
    valid_d   = i_enable;
  end

  // Mode is tracked every cycle so a switch while disabled still unprimes the lanes.
  assign clr_primed = (i_rx_mode != rx_mode_q);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_mode_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      rx_mode_q <= rx_mode_d;
      valid_q   <= valid_d;
    end
  end

  assign o_valid = valid_q;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    bip_lane_acc #(
      .ERR_CNT_W (ERR_CNT_W)
    ) u_lane (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_enable     (i_enable),
      .i_rx_mode    (i_rx_mode),
      .i_clear_cnt  (i_clear_cnt),
      .i_clr_primed (clr_primed),
      .i_am         (i_am_insert[g]),
      .i_err_inject (err_inject_w[g]),
      .i_block      (i_data[g*LEN_CODED_BLOCK +: LEN_CODED_BLOCK]),
      .o_block      (o_data[g*LEN_CODED_BLOCK +: LEN_CODED_BLOCK]),
      .o_bip3       (o_bip3[g*8 +: 8]),
      .o_bip_error  (o_bip_error[g]),
      .o_err_count  (o_err_count[g*ERR_CNT_W +: ERR_CNT_W])
    );
  end

endmodule

// File: tb/tb_bip_multilane_calc.sv
module tb_bip_multilane_calc;

  localparam int NL = 20;
  localparam int W  = NL * 66;
  localparam logic [65:0]   ZB  = 66'h1_0000_0000_0000_0000;
  localparam logic [NL-1:0] ALL = {NL{1'b1}};
  localparam logic [NL-1:0] L0  = NL'(1);
  localparam logic [NL-1:0] L3  = NL'(1) << 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, en, rxm, clr;
  logic [W-1:0]  din;
  logic [NL-1:0] am;
`ifdef BIP_ERR_INJECT_EN
  logic [NL-1:0] inj;
`endif

  logic [W-1:0]     dout, dout4;
  logic             val, val4;
  logic [NL*8-1:0]  bip3, bip3_4;
  logic [NL-1:0]    berr, berr4;
  logic [NL*16-1:0] cnt;
  logic [NL*4-1:0]  cnt4;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] lb_out [80];

  bip_multilane_calc #(.N_LANES(NL), .LEN_CODED_BLOCK(66), .ERR_CNT_W(16)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_rx_mode(rxm), .i_clear_cnt(clr),
    .i_data(din), .i_am_insert(am),
`ifdef BIP_ERR_INJECT_EN
    .i_err_inject(inj),
`endif
    .o_data(dout), .o_valid(val), .o_bip3(bip3), .o_bip_error(berr), .o_err_count(cnt)
  );

  bip_multilane_calc #(.N_LANES(NL), .LEN_CODED_BLOCK(66), .ERR_CNT_W(4)) dut4 (
    .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_rx_mode(rxm), .i_clear_cnt(clr),
    .i_data(din), .i_am_insert(am),
`ifdef BIP_ERR_INJECT_EN
    .i_err_inject(inj),
`endif
    .o_data(dout4), .o_valid(val4), .o_bip3(bip3_4), .o_bip_error(berr4), .o_err_count(cnt4)
  );

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7 - i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every lane gets the zero-payload block ZB; AM lanes carry f3 in the BIP3
  // field, flipped lanes get D[2] (lane bit 63) inverted.
  task automatic drive(input logic [NL-1:0] a, input logic [NL-1:0] flip, input logic [7:0] f3);
    for (int l = 0; l < NL; l++) begin
      logic [65:0] b;
      b = ZB;
      if (a[l]) b[39:32] = rev8(f3);
      if (flip[l]) b[63] = ~b[63];
      din[l*66 +: 66] = b;
    end
    am = a;
    en = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    int pbad;
    logic [NL-1:0] err_or;
    logic [95:0] r;

    rst_n = 1'b0; en = 1'b0; rxm = 1'b0; clr = 1'b0; din = '0; am = '0;
`ifdef BIP_ERR_INJECT_EN
    inj = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", val, 1'b0);
    chk("reset_data_zero", dout === '0, 1'b1);
    chk("reset_bip3_zero", bip3 === '0, 1'b1);
    chk("reset_cnt_zero", cnt === '0, 1'b1);
    chk("reset_err", berr, '0);
    rst_n = 1'b1;
    tick();

    // TX lane 0: three zero-payload blocks (P=0x10 each), then an AM.
    drive('0, '0, 8'h00);
    drive('0, '0, 8'h00);
    drive('0, '0, 8'h00);
    drive(L0, '0, 8'h00);
    chk("tx_bip3_l0", bip3[7:0], 8'h10);
    chk("tx_am_block_l0", dout[65:0], 66'h1_0000_0008_0000_00F7);
    chk("tx_pass_l1", dout[131:66], ZB);
    chk("tx_bip3_l1", bip3[15:8], 8'h00);
    chk("tx_valid", val, 1'b1);

    // TX random stream with staggered AMs, captured for RX loopback.
    bad = 0;
    for (int c = 0; c < 80; c++) begin
      for (int l = 0; l < NL; l++) begin
        r = {$urandom(), $urandom(), $urandom()};
        din[l*66 +: 66] = r[65:0];
        am[l] = ((c % 8) == (l % 8));
      end
      en = 1'b1;
      tick();
      lb_out[c] = dout;
      for (int l = 0; l < NL; l++) begin
        if (am[l] && (dout[l*66 + 7 -: 8] !== ~dout[l*66 + 39 -: 8])) bad++;
      end
    end
    chk("tx_bip7_is_not_bip3", bad, 0);

    rxm = 1'b1;
    err_or = '0;
    pbad = 0;
    for (int c = 0; c < 80; c++) begin
      din = lb_out[c];
      for (int l = 0; l < NL; l++) am[l] = ((c % 8) == (l % 8));
      tick();
      err_or = err_or | berr;
      if (dout !== lb_out[c]) pbad++;
    end
    chk("loop_no_error", err_or, '0);
    chk("loop_passthrough", pbad, 0);
    chk("loop_cnt16_zero", cnt === '0, 1'b1);
    chk("loop_cnt4_zero", cnt4 === '0, 1'b1);

    // Fresh RX run: ZB stream, AM every 4th block, BIP3 field 0 is correct.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    en = 1'b0;
    tick();
    tick();
    chk("idle_valid", val, 1'b0);
    drive(ALL, '0, 8'h00);
    chk("rx_prime_no_err", berr, '0);
    drive('0, '0, 8'h00);
    drive('0, '0, 8'h00);
    drive('0, '0, 8'h00);
    drive(ALL, '0, 8'h00);
    chk("rx_clean_period", berr, '0);
    drive('0, L3, 8'h00);
    drive('0, '0, 8'h00);
    drive('0, '0, 8'h00);
    drive(ALL, '0, 8'h00);
    chk("rx_err_pulse_l3", berr, L3);
    chk("rx_bip3_l3", bip3[31:24], 8'h01);
    chk("rx_cnt_l3", cnt[63:48], 16'd1);
    chk("rx_cnt_l0", cnt[15:0], 16'd0);

    // Lane 0 corrupted in 20 consecutive periods.
    for (int k = 1; k <= 20; k++) begin
      drive('0, L0, 8'h00);
      if (k == 1) chk("rx_pulse_one_cycle", berr, '0);
      drive('0, '0, 8'h00);
      drive('0, '0, 8'h00);
      drive(ALL, '0, 8'h00);
      if (k == 14) chk("sat_cnt4_14", cnt4[3:0], 4'hE);
      if (k == 15) chk("sat_cnt4_15", cnt4[3:0], 4'hF);
    end
    chk("sat_cnt4_hold", cnt4[3:0], 4'hF);
    chk("cnt16_l0_20", cnt[15:0], 16'd20);
    chk("sat_err_l0_only", berr, L0);

    drive('0, L0, 8'h00);
    drive('0, '0, 8'h00);
    drive('0, '0, 8'h00);
    clr = 1'b1;
    drive(ALL, '0, 8'h00);
    clr = 1'b0;
    chk("clear_wins_cnt16", cnt === '0, 1'b1);
    chk("clear_wins_cnt4", cnt4 === '0, 1'b1);

    // Async reset mid-period, then two AMs with a wrong BIP3.
    drive('0, '0, 8'h00);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_outputs_zero",
        (dout === '0) && (bip3 === '0) && (cnt === '0) && (berr === '0) && (val === 1'b0), 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    en = 1'b0;
    tick();
    tick();
    drive('0, '0, 8'h00);
    drive(ALL, '0, 8'h01);
    chk("rst_first_am_no_err", berr, '0);
    chk("rst_first_am_cnt", cnt[15:0], 16'd0);
    drive('0, '0, 8'h00);
    drive('0, '0, 8'h00);
    drive(ALL, '0, 8'h01);
    chk("rst_second_am_err", berr, ALL);
    chk("rst_second_am_bip3", bip3[7:0], 8'h11);
    chk("rst_second_am_cnt_l19", cnt[319:304], 16'd1);

`ifdef BIP_ERR_INJECT_EN
    rst_n = 1'b0;
    rxm = 1'b0;
    tick();
    rst_n = 1'b1;
    en = 1'b0;
    tick();
    for (int c = 0; c < 16; c++) begin
      inj = (c == 8) ? (NL'(1) << 5) : '0;
      drive(((c % 4) == 0) ? ALL : '0, '0, 8'h00);
      lb_out[c] = dout;
      if (c == 8) chk("inj_bip3_uncorrupted", bip3[47:40], 8'hFF);
    end
    inj = '0;
    rxm = 1'b1;
    for (int c = 0; c < 16; c++) begin
      din = lb_out[c];
      am = ((c % 4) == 0) ? ALL : '0;
      tick();
      if (c == 8) chk("inj_err_l5", berr, NL'(1) << 5);
      if (c == 12) chk("inj_next_clean", berr, '0);
    end
    chk("inj_cnt_l5", cnt[95:80], 16'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
